// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the wait-state data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sext);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sext & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sext & sh[15]}}, sh[15:0]};
      SZ_WORD: return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: alignment check, write mask, store replication, load extension.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] rd_word,
  output logic        misalign,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_data,
  output logic [31:0] load_data
);

  always_comb begin
    misalign = 1'b1;
    wr_data  = store_data;
    case (size)
      SZ_BYTE: begin
        misalign = 1'b0;
        wr_data  = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        misalign = offset[0];
        wr_data  = {2{store_data[15:0]}};
      end
      SZ_WORD: misalign = |offset;
      default: misalign = 1'b1;
    endcase
    wr_mask   = misalign ? 4'b0000 : lane_mask(size, offset);
    load_data = misalign ? 32'h0 : load_extract(rd_word, size, offset, sign_ext);
  end

endmodule

// File: rtl/dm_wait.sv
// Data memory with req/ready handshake, programmable wait states and sub-word access.
module dm_wait
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        ready,
  output logic [31:0] data_out,
  output logic        misalign_err
);

  localparam int unsigned AW = DEPTH_LOG2 + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sext_q, sext_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic [31:0]     dout_q, dout_d;
  logic            err_q, err_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] rd_word, wr_data, load_data;
  logic [3:0]  wr_mask;
  logic        misalign, access, wr_en;
  logic        unused_addr;

  // Upper address bits alias onto the array.
  assign unused_addr = ^address[31:AW];
  assign idx    = addr_q[AW-1:2];
  assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign wr_en  = access && we_q && !reset;

  dm_lane_unit u_lane (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .sign_ext   (sext_q),
    .store_data (wdata_q),
    .rd_word    (rd_word),
    .misalign   (misalign),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data),
    .load_data  (load_data)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [2**DEPTH_LOG2];
      always_ff @(posedge clock) begin
        if (wr_en && wr_mask[gi])
          lane_mem[idx] <= wr_data[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = lane_mem[idx];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    dout_d  = 32'h0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = address[AW-1:0];
          wdata_d = data_in;
          cnt_d   = WAIT_INIT;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          dout_d  = we_q ? 32'h0 : load_data;
          err_d   = misalign;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
    we_q    <= we_d;
    size_q  <= size_d;
    sext_q  <= sext_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign busy         = busy_q;
  assign ready        = ready_q;
  assign data_out     = dout_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_dm_wait.sv
// Directed bench: table of memory ops on a WAIT_CYCLES=2 instance, plus timing/reset sequences.
module tb_dm_wait;

  logic        clock;
  logic        reset;
  logic        req_a, we_a, sx_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, din_a;
  logic        busy_a, ready_a, err_a;
  logic [31:0] dout_a;
  logic        req_b, we_b, sx_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, din_b;
  logic        busy_b, ready_b, err_b;
  logic [31:0] dout_b;

  int total = 0;
  int bad   = 0;

  dm_wait #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .we(we_a), .size(size_a),
    .sign_ext(sx_a), .address(addr_a), .data_in(din_a), .busy(busy_a),
    .ready(ready_a), .data_out(dout_a), .misalign_err(err_a));

  dm_wait #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .we(we_b), .size(size_b),
    .sign_ext(sx_b), .address(addr_b), .data_in(din_b), .busy(busy_b),
    .ready(ready_b), .data_out(dout_b), .misalign_err(err_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One transaction on dut_a; checks busy, latency, results and single-cycle ready.
  task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err);
    int lat;
    req_a = 1'b1; we_a = w; size_a = sz; sx_a = sx; addr_a = a; din_a = d;
    @(posedge clock); #1;
    req_a = 1'b0; we_a = ~w; size_a = ~sz; sx_a = ~sx; addr_a = ~a; din_a = ~d;
    chk({tag, ".busy"}, 32'(busy_a), 32'd1);
    lat = 1;
    while (!ready_a && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".data"}, dout_a, exp_data);
    chk({tag, ".err"}, 32'(err_a), 32'(exp_err));
    $display("op %s we=%0b size=%0d sx=%0b addr=%h din=%h -> data=%h err=%0b lat=%0d",
             tag, w, sz, sx, a, d, dout_a, err_a, lat);
    @(posedge clock); #1;
    chk({tag, ".pulse"}, 32'(ready_a), 32'd0);
  endtask

  vec_t vecs[21];
  logic exp_rdy [6];
  logic exp_bsy [6];
  int   seen;

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h12,   32'hFFFFFF5A, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDE5ABEEF, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h12,   32'h0,        32'h0000005A, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'h000000DE, 1'b0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h20,   32'h11112222, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h20,   32'hABCD8001, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h20,   32'h0,        32'hFFFF8001, 1'b0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h20,   32'h0,        32'h00008001, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h21,   32'h00007777, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h11118001, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h22,   32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h20,   32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        32'h00001111, 1'b0};
    vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'h40,   32'hAAAA5555, 32'h0,        1'b0};
    vecs[19] = '{1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        32'hFFFFFFBE, 1'b0};
    vecs[20] = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'h000000EF, 1'b0};

    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; size_a = 2'b00; sx_a = 1'b0; addr_a = 32'h0; din_a = 32'h0;
    req_b = 1'b0; we_b = 1'b0; size_b = 2'b10; sx_b = 1'b0; addr_b = 32'h0; din_b = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst.busy",  32'(busy_a),  32'd0);
    chk("rst.ready", 32'(ready_a), 32'd0);
    chk("rst.data",  dout_a,       32'h0);
    chk("rst.err",   32'(err_a),   32'd0);
    chk("rst.b_ready", 32'(ready_b), 32'd0);

    for (int i = 0; i < 21; i++)
      run_op($sformatf("v%0d", i), vecs[i].w, vecs[i].sz, vecs[i].sx, vecs[i].addr,
             vecs[i].din, vecs[i].exp_data, vecs[i].exp_err);

    // Reset lands on the edge that would commit the store.
    req_a = 1'b1; we_a = 1'b1; size_a = 2'b10; addr_a = 32'h40; din_a = 32'h12345678;
    @(posedge clock); #1;
    req_a = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort.busy",  32'(busy_a),  32'd0);
    chk("abort.ready", 32'(ready_a), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (ready_a) seen++;
    end
    chk("abort.no_ready", 32'(seen), 32'd0);
    $display("op abort: reset during WAIT, ready pulses seen=%0d", seen);
    run_op("abort.reload", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hAAAA5555, 1'b0);

    // Zero-wait instance with req held high across RESP.
    exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_bsy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    req_b = 1'b1; we_b = 1'b0; size_b = 2'b10; addr_b = 32'h10;
    for (int e = 0; e < 6; e++) begin
      @(posedge clock); #1;
      chk($sformatf("w0.ready.e%0d", e), 32'(ready_b), 32'(exp_rdy[e]));
      chk($sformatf("w0.busy.e%0d", e),  32'(busy_b),  32'(exp_bsy[e]));
      $display("op w0 edge=%0d ready=%0b busy=%0b", e, ready_b, busy_b);
    end
    req_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
